// File: rtl/vc_input_unit.sv
// Per-input-port VC unit: NUM_VC flit FIFOs, per-VC packet FSM, XY route, VC/switch requests, credit return.
// Optional macro VC_INPUT_LOOKAHEAD_EN: route a head on write into an empty VC and skip the ROUTING state.
module vc_input_unit #(
  parameter int NUM_VC          = 4,
  parameter int BUFFER_DEPTH    = 8,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int NUM_PORTS       = 5,
  parameter int NUM_ROUTERS     = 16,
  parameter int ROUTER_PER_ROW  = 4,
  parameter int ROUTER_ID       = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [$clog2(NUM_VC)-1:0]   in_vc,
  input  logic [FLIT_DATA_WIDTH-1:0]  in_data,
  output logic [NUM_VC-1:0]           va_req,
  output logic [NUM_VC*NUM_PORTS-1:0] va_port,
  input  logic [NUM_VC-1:0]           va_grant,
  input  logic [$clog2(NUM_VC)-1:0]   va_out_vc,
  output logic [NUM_VC-1:0]           sa_req,
  input  logic [NUM_VC-1:0]           sa_grant,
  output logic                        out_valid,
  output logic [FLIT_DATA_WIDTH-1:0]  out_data,
  output logic [NUM_PORTS-1:0]        out_port,
  output logic [$clog2(NUM_VC)-1:0]   out_vc,
  output logic                        credit_valid,
  output logic [$clog2(NUM_VC)-1:0]   credit_vc,
  output logic                        overflow_err
);

  localparam int VC_W    = $clog2(NUM_VC);
  localparam int PTR_W   = $clog2(BUFFER_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int RID_W   = $clog2(NUM_ROUTERS);
  localparam int W       = FLIT_DATA_WIDTH;
  localparam int CUR_ROW = ROUTER_ID / ROUTER_PER_ROW;
  localparam int CUR_COL = ROUTER_ID % ROUTER_PER_ROW;
  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_SOUTH = 2;
  localparam int P_EAST  = 3;
  localparam int P_WEST  = 4;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ROUTING  = 2'd1,
    S_VC_ALLOC = 2'd2,
    S_ACTIVE   = 2'd3
  } vc_state_t;

  // Dimension-ordered routing: resolve the column first, then the row.
  function automatic logic [NUM_PORTS-1:0] xy_route(input logic [RID_W-1:0] dest);
    int dst_row;
    int dst_col;
    logic [NUM_PORTS-1:0] port;
    dst_row = int'(dest) / ROUTER_PER_ROW;
    dst_col = int'(dest) % ROUTER_PER_ROW;
    port    = '0;
    if (dst_col > CUR_COL)      port[P_EAST]  = 1'b1;
    else if (dst_col < CUR_COL) port[P_WEST]  = 1'b1;
    else if (dst_row > CUR_ROW) port[P_SOUTH] = 1'b1;
    else if (dst_row < CUR_ROW) port[P_NORTH] = 1'b1;
    else                        port[P_LOCAL] = 1'b1;
    return port;
  endfunction

  function automatic logic is_head(input logic [1:0] ftype);
    return (ftype == 2'b00) || (ftype == 2'b11);
  endfunction

  function automatic logic is_tail(input logic [1:0] ftype);
    return ftype[1];
  endfunction

  function automatic logic grant_onehot(input logic [NUM_VC-1:0] g);
    return $onehot(g);
  endfunction

  logic [W-1:0]         r_mem    [NUM_VC][BUFFER_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr [NUM_VC];
  logic [PTR_W-1:0]     r_wr_ptr [NUM_VC];
  logic [CNT_W-1:0]     r_count  [NUM_VC];
  vc_state_t            r_state  [NUM_VC];
  vc_state_t            w_next_state [NUM_VC];
  logic [NUM_PORTS-1:0] r_route  [NUM_VC];
  logic [VC_W-1:0]      r_ovc    [NUM_VC];
  logic [W-1:0]         w_front  [NUM_VC];
  logic [NUM_VC-1:0]    w_empty;
  logic [NUM_VC-1:0]    w_full;
  logic [NUM_VC-1:0]    w_front_head;
  logic [NUM_VC-1:0]    w_front_tail;
  logic [NUM_VC-1:0]    w_push;
  logic [NUM_VC-1:0]    w_pop;
  logic                 w_drop;
  logic                 w_pop_any;
  logic [VC_W-1:0]      w_pop_idx;

  logic                 r_out_valid;
  logic [W-1:0]         r_out_data;
  logic [NUM_PORTS-1:0] r_out_port;
  logic [VC_W-1:0]      r_out_vc;
  logic                 r_credit_valid;
  logic [VC_W-1:0]      r_credit_vc;
  logic                 r_overflow;

`ifdef VC_INPUT_LOOKAHEAD_EN
  logic [NUM_VC-1:0]    r_la_valid;
  logic [NUM_PORTS-1:0] r_la_port [NUM_VC];
`endif

  // FIFO status, push/pop qualification. A pop frees its slot before a same-cycle push.
  always_comb begin
    w_drop    = 1'b0;
    w_pop_idx = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_front[v]      = r_mem[v][r_rd_ptr[v]];
      w_empty[v]      = (r_count[v] == '0);
      w_full[v]       = (r_count[v] == FULL_CNT);
      w_front_head[v] = is_head(w_front[v][W-1:W-2]);
      w_front_tail[v] = is_tail(w_front[v][W-1:W-2]);
      w_pop[v]        = grant_onehot(sa_grant) && sa_grant[v] && sa_req[v];
      w_push[v]       = in_valid && (in_vc == VC_W'(v)) && (!w_full[v] || w_pop[v]);
      w_drop          = w_drop || (in_valid && (in_vc == VC_W'(v)) && w_full[v] && !w_pop[v]);
      w_pop_idx       = w_pop[v] ? VC_W'(v) : w_pop_idx;
    end
  end

  assign w_pop_any = |w_pop;

  // Flit storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_push[v]) r_mem[v][r_wr_ptr[v]] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_push[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
        if (w_pop[v])  r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
        r_count[v] <= r_count[v] + CNT_W'(w_push[v]) - CNT_W'(w_pop[v]);
      end
    end
  end

  // Per-VC state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) r_state[v] <= S_IDLE;
    end else begin
      for (int v = 0; v < NUM_VC; v++) r_state[v] <= w_next_state[v];
    end
  end

  // Per-VC next state; a body/tail at the front of an idle VC is left in place.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_next_state[v] = r_state[v];
      case (r_state[v])
        S_IDLE: begin
          if (!w_empty[v] && w_front_head[v]) begin
`ifdef VC_INPUT_LOOKAHEAD_EN
            if (r_la_valid[v]) w_next_state[v] = S_VC_ALLOC;
            else               w_next_state[v] = S_ROUTING;
`else
            w_next_state[v] = S_ROUTING;
`endif
          end else begin
            w_next_state[v] = S_IDLE;
          end
        end
        S_ROUTING:  w_next_state[v] = S_VC_ALLOC;
        S_VC_ALLOC: begin
          if (va_grant[v]) w_next_state[v] = S_ACTIVE;
          else             w_next_state[v] = S_VC_ALLOC;
        end
        S_ACTIVE: begin
          if (w_pop[v] && w_front_tail[v]) w_next_state[v] = S_IDLE;
          else                             w_next_state[v] = S_ACTIVE;
        end
        default: w_next_state[v] = S_IDLE;
      endcase
    end
  end

  // Allocator requests decoded from the per-VC state.
  always_comb begin
    va_req  = '0;
    sa_req  = '0;
    va_port = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      va_req[v] = (r_state[v] == S_VC_ALLOC);
      sa_req[v] = (r_state[v] == S_ACTIVE) && (r_count[v] != '0);
      va_port[v*NUM_PORTS +: NUM_PORTS] = va_req[v] ? r_route[v] : '0;
    end
  end

  // Latched output port and downstream VC per packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_route[v] <= '0;
        r_ovc[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        case (r_state[v])
          S_ROUTING:  r_route[v] <= xy_route(w_front[v][W-3 -: RID_W]);
`ifdef VC_INPUT_LOOKAHEAD_EN
          S_IDLE:     if (w_next_state[v] == S_VC_ALLOC) r_route[v] <= r_la_port[v];
`endif
          S_VC_ALLOC: if (va_grant[v]) r_ovc[v] <= va_out_vc;
          default:    r_route[v] <= r_route[v];
        endcase
      end
    end
  end

`ifdef VC_INPUT_LOOKAHEAD_EN
  // Early route of a head landing in an empty VC; it is that VC's next front flit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_la_valid <= '0;
      for (int v = 0; v < NUM_VC; v++) r_la_port[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_push[v] && w_empty[v] && is_head(in_data[W-1:W-2])) begin
          r_la_valid[v] <= 1'b1;
          r_la_port[v]  <= xy_route(in_data[W-3 -: RID_W]);
        end else if (w_pop[v] || ((r_state[v] == S_IDLE) && (w_next_state[v] != S_IDLE))) begin
          r_la_valid[v] <= 1'b0;
        end
      end
    end
  end
`endif

  // Registered switch output and credit return, plus sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_port     <= '0;
      r_out_vc       <= '0;
      r_credit_valid <= 1'b0;
      r_credit_vc    <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_out_valid    <= w_pop_any;
      r_credit_valid <= w_pop_any;
      r_overflow     <= r_overflow | w_drop;
      if (w_pop_any) begin
        r_out_data  <= w_front[w_pop_idx];
        r_out_port  <= r_route[w_pop_idx];
        r_out_vc    <= r_ovc[w_pop_idx];
        r_credit_vc <= w_pop_idx;
      end else begin
        r_out_data  <= '0;
        r_out_port  <= '0;
        r_out_vc    <= '0;
        r_credit_vc <= '0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_port     = r_out_port;
  assign out_vc       = r_out_vc;
  assign credit_valid = r_credit_valid;
  assign credit_vc    = r_credit_vc;
  assign overflow_err = r_overflow;

endmodule
